// File: rtl/mute_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mute_window_gen : N-channel trigger -> delay -> mute -> hold-off generator |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mute_window_gen #(
  parameter int NCH = 1,
  parameter int CW  = 12,
  parameter int DW  = 8,
  parameter int MW  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic [DW-1:0]     delay_i,
  input  logic [CW-1:0]     length_i,
  input  logic [CW-1:0]     holdoff_i,
  input  logic              clear_i,
  input  logic [NCH-1:0]    trig_i,
  output logic [NCH-1:0]    mute_n_o,
  output logic [NCH-1:0]    busy_o,
  output logic              any_mute_o,
  output logic [NCH*MW-1:0] missed_o
);

  localparam int KW = (CW > DW) ? CW : DW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_MUTE  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [1:0] M_RETRIG = 2'd1;
  localparam logic [1:0] M_GATED  = 2'd2;

  localparam logic [KW-1:0] CNT_ONE  = KW'(1);
  localparam logic [MW-1:0] MISS_ONE = MW'(1);
  localparam logic [MW-1:0] MISS_MAX = {MW{1'b1}};

  logic [NCH-1:0] trig_prev_q;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] mute_nxt;
  logic           any_mute_q;

  assign rise = trig_i & ~trig_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_prev_q <= '0;
      any_mute_q  <= 1'b0;
    end else begin
      trig_prev_q <= trig_i;
      any_mute_q  <= |mute_nxt;
    end
  end

  assign any_mute_o = any_mute_q;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [1:0]    state_q, state_d;
      logic [KW-1:0] cnt_q, cnt_d;
      logic [1:0]    mode_q, mode_d;
      logic [DW-1:0] dly_q, dly_d;
      logic [CW-1:0] len_q, len_d;
      logic [CW-1:0] hld_q, hld_d;
      logic [MW-1:0] missed_q, missed_d;
      logic          mute_n_q;
      logic          busy_q;
      logic          reject;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dly_d   = dly_q;
        len_d   = len_q;
        hld_d   = hld_q;
        reject  = 1'b0;

        // Disabling aborts any window and swallows rises without counting them.
        if (!enable_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (rise[i] && (length_i != '0)) begin
                mode_d = mode_i;
                dly_d  = delay_i;
                len_d  = length_i;
                hld_d  = holdoff_i;
                if (delay_i != '0) begin
                  state_d = S_DELAY;
                  cnt_d   = KW'(delay_i);
                end else begin
                  state_d = S_MUTE;
                  cnt_d   = KW'(length_i);
                end
              end
            end
            S_DELAY: begin
              reject = rise[i] && (mode_q != M_RETRIG);
              if (rise[i] && (mode_q == M_RETRIG)) begin
                cnt_d = KW'(dly_q);
              end else if (cnt_q == CNT_ONE) begin
                state_d = S_MUTE;
                cnt_d   = KW'(len_q);
              end else begin
                cnt_d = cnt_q - CNT_ONE;
              end
            end
            S_MUTE: begin
              reject = rise[i] && (mode_q != M_RETRIG);
              if (rise[i] && (mode_q == M_RETRIG)) begin
                cnt_d = KW'(len_q);
              end else if ((cnt_q == CNT_ONE) || ((mode_q == M_GATED) && !trig_i[i])) begin
                if (hld_q != '0) begin
                  state_d = S_HOLD;
                  cnt_d   = KW'(hld_q);
                end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                end
              end else begin
                cnt_d = cnt_q - CNT_ONE;
              end
            end
            default: begin
              reject = rise[i];
              if (cnt_q == CNT_ONE) begin
                state_d = S_IDLE;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q - CNT_ONE;
              end
            end
          endcase
        end
      end

      // Clear has priority over a same-cycle rejected rise.
      always_comb begin
        missed_d = missed_q;
        if (clear_i) begin
          missed_d = '0;
        end else if (reject && (missed_q != MISS_MAX)) begin
          missed_d = missed_q + MISS_ONE;
        end
      end

      assign mute_nxt[i] = (state_d == S_MUTE);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          mode_q   <= '0;
          dly_q    <= '0;
          len_q    <= '0;
          hld_q    <= '0;
          missed_q <= '0;
          mute_n_q <= 1'b1;
          busy_q   <= 1'b0;
        end else begin
          state_q  <= state_d;
          cnt_q    <= cnt_d;
          mode_q   <= mode_d;
          dly_q    <= dly_d;
          len_q    <= len_d;
          hld_q    <= hld_d;
          missed_q <= missed_d;
          mute_n_q <= ~mute_nxt[i];
          busy_q   <= (state_d != S_IDLE);
        end
      end

      assign mute_n_o[i]            = mute_n_q;
      assign busy_o[i]              = busy_q;
      assign missed_o[i*MW +: MW]   = missed_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mute_window_gen.sv
`default_nettype none
// Testbench for mute_window_gen: directed scenarios plus random traffic against a
// timestamp-based window model (mute start/end and busy end per channel).
module tb_mute_window_gen;
  localparam int NCH = 4;
  localparam int CW  = 12;
  localparam int DW  = 8;
  localparam int MW  = 4;
  localparam int MAXMISS = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [1:0]        mode;
  logic [DW-1:0]     delay;
  logic [CW-1:0]     length;
  logic [CW-1:0]     holdoff;
  logic              clear;
  logic [NCH-1:0]    trig;
  logic [NCH-1:0]    mute_n;
  logic [NCH-1:0]    busy;
  logic              any_mute;
  logic [NCH*MW-1:0] missed;

  int total = 0;
  int bad   = 0;

  // Model: per channel, absolute edge numbers of window start, mute start/end, busy end.
  int e;
  int st [NCH];
  int ms [NCH];
  int me [NCH];
  int be [NCH];
  int lmode [NCH];
  int ld [NCH];
  int ll [NCH];
  int lh [NCH];
  int miss [NCH];
  logic [NCH-1:0] tprev;
  int mcount;

  mute_window_gen #(.NCH(NCH), .CW(CW), .DW(DW), .MW(MW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .mode_i     (mode),
    .delay_i    (delay),
    .length_i   (length),
    .holdoff_i  (holdoff),
    .clear_i    (clear),
    .trig_i     (trig),
    .mute_n_o   (mute_n),
    .busy_o     (busy),
    .any_mute_o (any_mute),
    .missed_o   (missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      st[i] = -1; ms[i] = -1; me[i] = -1; be[i] = -1; miss[i] = 0;
      lmode[i] = 0; ld[i] = 0; ll[i] = 0; lh[i] = 0;
    end
    tprev = '0;
  endtask

  task automatic model_edge();
    logic rise;
    bit idle, indel, inmute, inc;
    e++;
    for (int i = 0; i < NCH; i++) begin
      rise = trig[i] & ~tprev[i];
      inc  = 0;
      idle = (e > be[i]);
      if (!enable) begin
        if (!idle) begin ms[i] = e; me[i] = e; be[i] = e; end
      end else if (idle) begin
        if (rise && (length != 0)) begin
          lmode[i] = int'(mode); ld[i] = int'(delay); ll[i] = int'(length); lh[i] = int'(holdoff);
          st[i] = e;
          ms[i] = e + ld[i];
          me[i] = ms[i] + ll[i];
          be[i] = me[i] + lh[i];
        end
      end else begin
        indel  = (e <= ms[i]);
        inmute = !indel && (e <= me[i]);
        if (rise) begin
          if (lmode[i] == 1 && indel) begin
            ms[i] = e + ld[i]; me[i] = ms[i] + ll[i]; be[i] = me[i] + lh[i];
          end else if (lmode[i] == 1 && inmute) begin
            me[i] = e + ll[i]; be[i] = me[i] + lh[i];
          end else begin
            inc = 1;
          end
        end
        if (lmode[i] == 2 && inmute && !trig[i]) begin
          me[i] = e; be[i] = e + lh[i];
        end
      end
      if (clear) miss[i] = 0;
      else if (inc && miss[i] < MAXMISS) miss[i]++;
    end
    tprev = trig;
  endtask

  task automatic check_all();
    logic [NCH-1:0]    em, eb;
    logic [NCH*MW-1:0] emiss;
    for (int i = 0; i < NCH; i++) begin
      em[i] = !((ms[i] <= e) && (e < me[i]));
      eb[i] = (st[i] <= e) && (e < be[i]);
      emiss[i*MW +: MW] = MW'(miss[i]);
    end
    chk("mute_n", 32'(mute_n), 32'(em));
    chk("busy", 32'(busy), 32'(eb));
    chk("any_mute", 32'(any_mute), 32'(~&em));
    chk("missed", 32'(missed), 32'(emiss));
  endtask

  task automatic step(input logic [NCH-1:0] t);
    trig = t;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (mute_n[0] === 1'b0) mcount++;
  endtask

  task automatic run(input int n, input logic [NCH-1:0] t);
    for (int k = 0; k < n; k++) step(t);
  endtask

  task automatic cfg(input logic [1:0] m, input int d, input int l, input int h);
    mode = m; delay = DW'(d); length = CW'(l); holdoff = CW'(h);
  endtask

  task automatic do_clear();
    clear = 1'b1; step('0); clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; trig = '0;
    cfg(2'd0, 0, 320, 0);
    e = 0; mcount = 0;
    model_reset();
    #12;
    chk("reset_mute_n", 32'(mute_n), 32'hF);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_any", 32'(any_mute), 32'h0);
    chk("reset_missed", 32'(missed), 32'h0);
    rst_n = 1'b1;

    // Oneshot, 320-cycle window with no delay.
    mcount = 0;
    step(4'b0001); run(330, 4'b0000);
    chk("t1_len", 32'(mcount), 32'd320);

    // Oneshot with delay and hold-off; second rise is rejected.
    cfg(2'd0, 5, 10, 4);
    mcount = 0;
    step(4'b0001); run(7, 4'b0000); step(4'b0001); run(20, 4'b0000);
    chk("t2_len", 32'(mcount), 32'd10);
    chk("t2_missed", 32'(missed[MW-1:0]), 32'd1);

    // Retrigger extends the window; a rise during hold-off is counted.
    do_clear();
    cfg(2'd1, 0, 10, 4);
    mcount = 0;
    step(4'b0001); run(5, 4'b0000); step(4'b0001); run(11, 4'b0000);
    chk("t3_len", 32'(mcount), 32'd16);
    chk("t3_missed0", 32'(missed[MW-1:0]), 32'd0);
    step(4'b0001); run(5, 4'b0000);
    chk("t3_missed1", 32'(missed[MW-1:0]), 32'd1);

    // Gated: short level ends early, long level is capped and does not re-mute.
    cfg(2'd2, 0, 50, 3);
    mcount = 0;
    run(20, 4'b0001); run(10, 4'b0000);
    chk("t4_short", 32'(mcount), 32'd20);
    mcount = 0;
    run(100, 4'b0001); run(10, 4'b0000);
    chk("t4_long", 32'(mcount), 32'd50);

    // Independent channels, then a global abort.
    cfg(2'd0, 2, 30, 2);
    step(4'b0001); run(6, 4'b0000); step(4'b0100); run(10, 4'b0000);
    chk("t5_both", 32'(mute_n), 32'b1010);
    enable = 1'b0;
    run(2, 4'b0000);
    chk("t5_abort", 32'(mute_n), 32'hF);
    enable = 1'b1;
    run(5, 4'b0000);

    // Saturation of the missed counter and clear priority.
    do_clear();
    cfg(2'd0, 0, 200, 0);
    step(4'b0001);
    for (int k = 0; k < 20; k++) begin step(4'b0000); step(4'b0001); end
    chk("t6_sat", 32'(missed[MW-1:0]), 32'd15);
    step(4'b0000);
    clear = 1'b1; step(4'b0001); clear = 1'b0;
    chk("t6_clear", 32'(missed[MW-1:0]), 32'd0);
    step(4'b0000);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_mute", 32'(mute_n), 32'hF);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;

    // Random traffic across all channels and modes.
    begin
      logic [NCH-1:0] t;
      t = '0;
      for (int k = 0; k < 800; k++) begin
        if ($urandom_range(0, 19) == 0)
          cfg(2'($urandom_range(0, 3)), $urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 5));
        enable = ($urandom_range(0, 39) != 0);
        clear  = ($urandom_range(0, 49) == 0);
        t = t ^ NCH'($urandom & $urandom);
        step(t);
      end
      clear = 1'b0; enable = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
